// File: rtl/lcd_status_reader.sv
// HD44780-style status reader: issues RS=0/RW=1 read cycles with programmable
// setup/strobe/hold timing, samples busy flag and address counter, optionally polls.
module lcd_status_reader #(
    parameter int unsigned T_AS      = 2,
    parameter int unsigned T_PW      = 12,
    parameter int unsigned T_SMP     = 10,
    parameter int unsigned T_AH      = 2,
    parameter int unsigned T_GAP     = 4,
    parameter int unsigned MAX_POLLS = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       poll,
    input  logic [7:0] lcd_db_in,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       db_oe,
    output logic       ready,
    output logic       done,
    output logic       busy_flag,
    output logic [6:0] addr,
    output logic       timeout
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_E_HIGH = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int unsigned T_M1    = (T_AS > T_PW) ? T_AS : T_PW;
    localparam int unsigned T_M2    = (T_M1 > T_AH) ? T_M1 : T_AH;
    localparam int unsigned T_MAX   = (T_M2 > T_GAP) ? T_M2 : T_GAP;
    localparam int unsigned TCW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int unsigned PCW_RAW = $clog2(MAX_POLLS + 1);
    localparam int unsigned PCW     = (PCW_RAW > 8) ? PCW_RAW : 8;
    localparam int unsigned GAP_LAST = (T_GAP > 0) ? (T_GAP - 1) : 0;

    logic [2:0]     state, state_nx;
    logic [TCW-1:0] tcnt, tcnt_nx;
    logic [PCW-1:0] pcnt, pcnt_nx, pcnt_inc;
    logic           poll_mode, poll_mode_nx;
    logic           timeout_nx, busy_nx;
    logic [6:0]     addr_nx;
    logic           active_nx;

    // Next-state, counters and capture values
    always_comb begin
        state_nx     = state;
        tcnt_nx      = tcnt + TCW'(1);
        pcnt_nx      = pcnt;
        poll_mode_nx = poll_mode;
        timeout_nx   = timeout;
        busy_nx      = busy_flag;
        addr_nx      = addr;
        pcnt_inc     = (pcnt == {PCW{1'b1}}) ? pcnt : pcnt + PCW'(1);

        case (state)
            S_IDLE: begin
                tcnt_nx = '0;
                if (start) begin
                    state_nx     = S_SETUP;
                    poll_mode_nx = poll;
                    pcnt_nx      = '0;
                    timeout_nx   = 1'b0;
                end
            end
            S_SETUP: begin
                if (tcnt == TCW'(T_AS - 1)) begin
                    state_nx = S_E_HIGH;
                    tcnt_nx  = '0;
                end
            end
            S_E_HIGH: begin
                if (tcnt == TCW'(T_SMP - 1)) begin
                    busy_nx = lcd_db_in[7];
                    addr_nx = lcd_db_in[6:0];
                end
                if (tcnt == TCW'(T_PW - 1)) begin
                    state_nx = S_HOLD;
                    tcnt_nx  = '0;
                end
            end
            S_HOLD: begin
                if (tcnt == TCW'(T_AH - 1)) begin
                    tcnt_nx = '0;
                    if (!poll_mode || !busy_flag) begin
                        state_nx = S_DONE;
                    end else begin
                        pcnt_nx = pcnt_inc;
                        if (pcnt_inc >= PCW'(MAX_POLLS)) begin
                            timeout_nx = 1'b1;
                            state_nx   = S_DONE;
                        end else if (T_GAP == 0) begin
                            state_nx = S_SETUP;
                        end else begin
                            state_nx = S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                if (tcnt == TCW'(GAP_LAST)) begin
                    state_nx = S_SETUP;
                    tcnt_nx  = '0;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                tcnt_nx  = '0;
            end
            default: begin
                state_nx = S_IDLE;
                tcnt_nx  = '0;
            end
        endcase

        active_nx = (state_nx == S_SETUP) || (state_nx == S_E_HIGH) ||
                    (state_nx == S_HOLD)  || (state_nx == S_GAP);
    end

    // State register; bus-control outputs are registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tcnt      <= '0;
            pcnt      <= '0;
            poll_mode <= 1'b0;
            LCD_E     <= 1'b0;
            LCD_RS    <= 1'b0;
            LCD_RW    <= 1'b0;
            db_oe     <= 1'b1;
            ready     <= 1'b1;
            done      <= 1'b0;
            busy_flag <= 1'b1;
            addr      <= 7'd0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nx;
            tcnt      <= tcnt_nx;
            pcnt      <= pcnt_nx;
            poll_mode <= poll_mode_nx;
            LCD_E     <= (state_nx == S_E_HIGH);
            LCD_RS    <= 1'b0;
            LCD_RW    <= active_nx;
            db_oe     <= !active_nx;
            ready     <= (state_nx == S_IDLE);
            done      <= (state_nx == S_DONE);
            busy_flag <= busy_nx;
            addr      <= addr_nx;
            timeout   <= timeout_nx;
        end
    end

endmodule

// File: tb/tb_lcd_status_reader.sv
// Bench for lcd_status_reader: default instance plus a MAX_POLLS=3 instance,
// each checked cycle by cycle against a phase-sequence model of the read protocol.
module tb_lcd_status_reader;

    localparam int unsigned T_AS  = 2;
    localparam int unsigned T_PW  = 12;
    localparam int unsigned T_SMP = 10;
    localparam int unsigned T_AH  = 2;
    localparam int unsigned T_GAP = 4;

    // {E, RS, RW, db_oe, ready, done}
    localparam logic [5:0] C_IDLE = 6'b000110;
    localparam logic [5:0] C_ACT  = 6'b001000;
    localparam logic [5:0] C_EH   = 6'b101000;
    localparam logic [5:0] C_DONE = 6'b000101;

    logic       clk = 1'b0;
    logic       rst, start, poll, sel;
    logic [7:0] db;
    logic       start_a, start_b;
    logic       e_a, rs_a, rw_a, oe_a, rdy_a, done_a, bf_a, to_a;
    logic       e_b, rs_b, rw_b, oe_b, rdy_b, done_b, bf_b, to_b;
    logic [6:0] addr_a, addr_b;
    logic [5:0] ctl_obs;
    logic [8:0] val_obs;

    assign start_a = start && !sel;
    assign start_b = start && sel;
    assign ctl_obs = sel ? {e_b, rs_b, rw_b, oe_b, rdy_b, done_b}
                         : {e_a, rs_a, rw_a, oe_a, rdy_a, done_a};
    assign val_obs = sel ? {bf_b, addr_b, to_b} : {bf_a, addr_a, to_a};

    always #5 clk = ~clk;

    lcd_status_reader dut_a (
        .clk(clk), .rst(rst), .start(start_a), .poll(poll), .lcd_db_in(db),
        .LCD_E(e_a), .LCD_RS(rs_a), .LCD_RW(rw_a), .db_oe(oe_a), .ready(rdy_a),
        .done(done_a), .busy_flag(bf_a), .addr(addr_a), .timeout(to_a)
    );

    lcd_status_reader #(.MAX_POLLS(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .poll(poll), .lcd_db_in(db),
        .LCD_E(e_b), .LCD_RS(rs_b), .LCD_RW(rw_b), .db_oe(oe_b), .ready(rdy_b),
        .done(done_b), .busy_flag(bf_b), .addr(addr_b), .timeout(to_b)
    );

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] plan[$];
    int         noise_mode  = 0;
    bit         pulse_start = 0;
    bit         hold_start  = 0;
    logic       exp_bf[2];
    logic [6:0] exp_ad[2];
    logic       exp_to[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input bit s);
        sel = s;
        #1;
    endtask

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            exp_bf[i] = 1'b1;
            exp_ad[i] = 7'd0;
            exp_to[i] = 1'b0;
        end
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < 2; i++) begin
            set_sel(i[0]);
            check({tag, "_ctl"}, 32'(ctl_obs), 32'(C_IDLE));
            check({tag, "_val"}, 32'(val_obs), 32'({1'b1, 7'd0, 1'b0}));
        end
    endtask

    // One transaction from the IDLE cycle through the return to ready
    task automatic run_txn(input bit s, input bit pm);
        int         maxp;
        int         polls;
        int         r;
        bit         fin;
        logic [7:0] smp;
        maxp  = s ? 3 : 255;
        polls = 0;
        r     = 0;
        fin   = 0;
        set_sel(s);
        poll  = pm;
        check("idle_ready", 32'(ctl_obs), 32'(C_IDLE));
        start = 1'b1;
        step();
        if (!hold_start) start = 1'b0;
        exp_to[s] = 1'b0;
        check("start_hold_vals", 32'(val_obs), 32'({exp_bf[s], exp_ad[s], 1'b0}));
        while (!fin) begin
            for (int i = 0; i < int'(T_AS); i++) begin
                check("setup", 32'(ctl_obs), 32'(C_ACT));
                step();
            end
            for (int j = 1; j <= int'(T_PW); j++) begin
                check("e_high", 32'(ctl_obs), 32'(C_EH));
                if (j == int'(T_SMP)) db = plan[r];
                else if (noise_mode == 1) db = (j < 11) ? 8'h00 : 8'hFF;
                else db = 8'($urandom);
                if (pulse_start) start = j[0];
                step();
            end
            if (!hold_start) start = 1'b0;
            smp = plan[r];
            r++;
            exp_bf[s] = smp[7];
            exp_ad[s] = smp[6:0];
            for (int i = 0; i < int'(T_AH); i++) begin
                check("hold", 32'(ctl_obs), 32'(C_ACT));
                step();
            end
            if (!pm || !smp[7]) begin
                fin = 1;
            end else begin
                polls++;
                if (polls >= maxp) begin
                    exp_to[s] = 1'b1;
                    fin = 1;
                end else begin
                    for (int i = 0; i < int'(T_GAP); i++) begin
                        check("gap", 32'(ctl_obs), 32'(C_ACT));
                        step();
                    end
                end
            end
        end
        check("done", 32'(ctl_obs), 32'(C_DONE));
        check("done_vals", 32'(val_obs), 32'({exp_bf[s], exp_ad[s], exp_to[s]}));
        step();
        check("ready_back", 32'(ctl_obs), 32'(C_IDLE));
        check("ready_vals", 32'(val_obs), 32'({exp_bf[s], exp_ad[s], exp_to[s]}));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; poll = 1'b0; sel = 1'b0; db = 8'h00;
        reset_model();
        step();
        step();
        check_reset("reset");
        rst = 1'b0;
        step();

        // single read of 0x85
        plan.delete(); plan.push_back(8'h85);
        run_txn(0, 0);

        // bus flips 00->FF on E cycle 11: must capture zeros
        noise_mode = 1;
        plan.delete(); plan.push_back(8'h00);
        run_txn(0, 0);
        noise_mode = 0;

        // poll: three busy reads then clear
        plan.delete();
        plan.push_back(8'h80); plan.push_back(8'h80); plan.push_back(8'h80); plan.push_back(8'h20);
        run_txn(0, 1);

        // poll with MAX_POLLS=3 and bus stuck busy: timeout
        plan.delete();
        for (int i = 0; i < 4; i++) plan.push_back(8'h80);
        run_txn(1, 1);

        // next accepted start clears timeout
        plan.delete(); plan.push_back(8'h33);
        run_txn(1, 0);

        // start pulsed during E_HIGH is ignored
        pulse_start = 1;
        plan.delete(); plan.push_back(8'hC1);
        run_txn(0, 0);
        pulse_start = 0;

        // start held high: immediate restart after ready, then reset out of SETUP
        hold_start = 1;
        plan.delete(); plan.push_back(8'h12);
        run_txn(0, 0);
        hold_start = 0;
        step();
        check("restart_setup", 32'(ctl_obs), 32'(C_ACT));
        rst = 1'b1; start = 1'b0;
        step();
        rst = 1'b0;
        reset_model();
        check_reset("reset_setup");

        // leave non-reset capture values, then reset on E_HIGH cycle 5
        plan.delete(); plan.push_back(8'h2A);
        run_txn(0, 0);
        set_sel(0);
        start = 1'b1; poll = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < int'(T_AS) + 4; i++) step();
        check("mid_e_high", 32'(ctl_obs), 32'(C_EH));
        check("mid_vals", 32'(val_obs), 32'({1'b0, 7'h2A, 1'b0}));
        rst = 1'b1;
        step();
        rst = 1'b0;
        reset_model();
        check_reset("reset_mid_e");

        // reset wins over simultaneous start
        set_sel(0);
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        check_reset("reset_vs_start");

        // randomized transactions
        for (int t = 0; t < 12; t++) begin
            bit s, pm;
            int nb;
            s  = ($urandom_range(0, 3) == 0);
            pm = $urandom_range(0, 1) == 1;
            plan.delete();
            if (!pm) begin
                plan.push_back(8'($urandom));
            end else begin
                nb = $urandom_range(0, 4);
                for (int i = 0; i < nb; i++) plan.push_back({1'b1, 7'($urandom)});
                plan.push_back({1'b0, 7'($urandom)});
            end
            run_txn(s, pm);
            for (int i = 0; i < $urandom_range(0, 2); i++) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_status_reader.md
LCD_STATUS_READER -- requirements
Module: lcd_status_reader

Interface
REQ-001 Parameter T_AS, default 2: clk cycles RS/RW setup before LCD_E rises.
REQ-002 Parameter T_PW, default 12: clk cycles LCD_E held high per read.
REQ-003 Parameter T_SMP, default 10: cycle within the LCD_E high window (1-based) on which the data bus is sampled.
REQ-004 Parameter T_AH, default 2: clk cycles RS/RW hold after LCD_E falls.
REQ-005 Parameter T_GAP, default 4: idle cycles between consecutive reads in poll mode.
REQ-006 Parameter MAX_POLLS, default 255: reads allowed in poll mode before timeout.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 start  input  1  request a status read; accepted only when ready=1.
REQ-010 poll  input  1  sampled with start; 1 = repeat reads until busy clears.
REQ-011 lcd_db_in  input  8  LCD data bus as read back (DB7 = busy flag, DB6..0 = address counter).
REQ-012 LCD_E  output  1  LCD enable strobe.
REQ-013 LCD_RS  output  1  register select (0 = instruction/status).
REQ-014 LCD_RW  output  1  1 = read.
REQ-015 db_oe  output  1  1 = writer side may drive the bus; 0 = bus released for the LCD to drive.
REQ-016 ready  output  1  idle, can accept start.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 busy_flag  output  1  last sampled DB7.
REQ-019 addr  output  7  last sampled DB6..0.
REQ-020 timeout  output  1  poll mode ended without busy clearing.

Function
REQ-021 The block SHALL implement the states IDLE, SETUP, E_HIGH, HOLD, GAP and DONE.
REQ-022 IDLE: ready=1, db_oe=1, LCD_E=0, LCD_RW=0, LCD_RS=0; start=1 at edge k SHALL move to SETUP at k+1, latch poll, clear the poll counter and clear timeout.
REQ-023 start SHALL be ignored in every state other than IDLE.
REQ-024 SETUP, E_HIGH, HOLD and GAP: LCD_RS=0, LCD_RW=1, db_oe=0, ready=0.
REQ-025 LCD_E SHALL be 1 only in E_HIGH, for exactly T_PW consecutive cycles per read.
REQ-026 SETUP SHALL last T_AS cycles and HOLD SHALL last T_AH cycles.
REQ-027 On the T_SMP-th E_HIGH cycle the block SHALL register busy_flag<=lcd_db_in[7] and addr<=lcd_db_in[6:0]; bus changes on any other cycle SHALL have no effect.
REQ-028 After HOLD in single mode (poll=0), the block SHALL enter DONE.
REQ-029 After HOLD in poll mode, if the sampled busy=0 the block SHALL enter DONE; otherwise it SHALL increment the poll counter.
REQ-030 In poll mode, if the poll counter reaches MAX_POLLS the block SHALL set timeout=1 and enter DONE; otherwise it SHALL spend T_GAP cycles in GAP and return to SETUP.
REQ-031 During GAP, LCD_E SHALL be 0 and RS/RW/db_oe SHALL keep their SETUP values.
REQ-032 DONE SHALL last one cycle with done=1, ready=0 and RS/RW/db_oe at IDLE values, then go to IDLE.
REQ-033 Latency: in single mode with defaults, done SHALL be 1 at k+1+T_AS+T_PW+T_AH = k+17, and ready SHALL be 1 at k+18.
REQ-034 busy_flag, addr and timeout SHALL hold their values until the next sample or the next accepted start.
REQ-035 The poll counter SHALL be at least 8 bits wide and SHALL saturate (never wrap); timing counters SHALL be wide enough for the largest timing parameter.
REQ-036 Legal parameter ranges: T_AS, T_PW, T_AH, MAX_POLLS >= 1; 1 <= T_SMP <= T_PW; T_GAP >= 0, where T_GAP = 0 skips GAP.

Reset
REQ-037 rst=1 at any edge, including mid-transaction, SHALL force IDLE on that edge.
REQ-038 Reset values: LCD_E=0, LCD_RS=0, LCD_RW=0, db_oe=1, ready=1, done=0, busy_flag=1, addr=0, timeout=0.
REQ-039 rst SHALL take priority over a simultaneous start.

Verification
REQ-040 Single read, lcd_db_in=8'h85, start at k -> LCD_E high for exactly 12 cycles from k+3; done at k+17; busy_flag=1; addr=7'h05; timeout=0.
REQ-041 Poll mode, bus reads 8'h80 for 3 samples then 8'h20 -> 4 E pulses separated by 2+4+2 low cycles; done; busy_flag=0; addr=7'h20; timeout=0.
REQ-042 Poll mode, MAX_POLLS=3, bus constant 8'h80 -> exactly 3 E pulses; done with timeout=1; busy_flag=1.
REQ-043 Bus changes from 8'h00 to 8'hFF on E_HIGH cycle 11 -> captured busy_flag=0, addr=0.
REQ-044 start re-pulsed during E_HIGH -> ignored; start held high continuously -> a new transaction begins at the edge after ready returns to 1.
REQ-045 rst during E_HIGH cycle 5 -> next cycle LCD_E=0, RW=0, db_oe=1, ready=1, done stays 0, all outputs at reset values.
